// File: rtl/simon_round_ctrl.sv
// Round sequencer for Sly-Man-Says: grows a random colour pattern, plays it back
// on four LEDs with tick-timed on/off steps, then checks the player's presses.
module simon_round_ctrl #(
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] rnd,
    input  logic       btn_valid,
    input  logic [1:0] btn_color,
    output logic [3:0] led,
    output logic [5:0] round,
    output logic       showing,
    output logic       await_input,
    output logic       win,
    output logic       lose
);

    localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH  = 1 << AW;
    localparam int TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [5:0]    LEN_MAX  = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    state_t          state_r;
    logic [1:0]      mem_r [DEPTH];
    logic [5:0]      idx_r;
    logic [5:0]      round_r;
    logic [TW-1:0]   timer_r;
    logic [3:0]      led_r;
    logic            showing_r;
    logic            await_r;
    logic            win_r;
    logic            lose_r;

    logic [5:0]      idx_inc_s;
    logic [1:0]      cur_color_s;
    logic [1:0]      next_color_s;
    logic [1:0]      first_color_s;
    logic            last_step_s;
    logic            press_ok_s;
    logic [3:0]      echo_s;

    // Pattern lookups; the first step bypasses the entry being written in ADD
    always_comb begin
        idx_inc_s    = idx_r + 6'd1;
        cur_color_s  = mem_r[idx_r[AW-1:0]];
        next_color_s = mem_r[idx_inc_s[AW-1:0]];
        last_step_s  = (idx_r == (round_r - 6'd1));
        press_ok_s   = (btn_color == cur_color_s);
        if (round_r == 6'd0) begin
            first_color_s = rnd;
        end else begin
            first_color_s = mem_r[0];
        end
    end

    // Echo the player's press on the LEDs in the same cycle it arrives
    always_comb begin
        echo_s = 4'b0000;
        if (await_r && btn_valid) begin
            echo_s = onehot(btn_color);
        end else begin
            echo_s = 4'b0000;
        end
    end

    // Pattern storage; contents are irrelevant until written, so no reset
    always_ff @(posedge clk) begin
        if (state_r == S_ADD) begin
            mem_r[round_r[AW-1:0]] <= rnd;
        end
    end

    // Round sequencer: state, counters and registered display outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= S_IDLE;
            idx_r     <= 6'd0;
            round_r   <= 6'd0;
            timer_r   <= '0;
            led_r     <= 4'b0000;
            showing_r <= 1'b0;
            await_r   <= 1'b0;
            win_r     <= 1'b0;
            lose_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        round_r <= 6'd0;
                        state_r <= S_ADD;
                    end
                end
                S_ADD: begin
                    round_r   <= round_r + 6'd1;
                    idx_r     <= 6'd0;
                    timer_r   <= '0;
                    led_r     <= onehot(first_color_s);
                    showing_r <= 1'b1;
                    state_r   <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (tick) begin
                        if (timer_r == ON_LAST) begin
                            timer_r <= '0;
                            led_r   <= 4'b0000;
                            state_r <= S_SHOW_OFF;
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                end
                S_SHOW_OFF: begin
                    if (tick) begin
                        if (timer_r == OFF_LAST) begin
                            timer_r <= '0;
                            if (last_step_s) begin
                                idx_r     <= 6'd0;
                                showing_r <= 1'b0;
                                await_r   <= 1'b1;
                                state_r   <= S_INPUT;
                            end else begin
                                idx_r   <= idx_inc_s;
                                led_r   <= onehot(next_color_s);
                                state_r <= S_SHOW_ON;
                            end
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                end
                S_INPUT: begin
                    // A press outranks a coincident tick and restarts the timeout
                    if (btn_valid) begin
                        timer_r <= '0;
                        if (!press_ok_s) begin
                            await_r <= 1'b0;
                            lose_r  <= 1'b1;
                            state_r <= S_LOSE;
                        end else if (last_step_s) begin
                            await_r <= 1'b0;
                            if (round_r == LEN_MAX) begin
                                win_r   <= 1'b1;
                                led_r   <= 4'b1111;
                                state_r <= S_WIN;
                            end else begin
                                state_r <= S_ADD;
                            end
                        end else begin
                            idx_r <= idx_inc_s;
                        end
                    end else if (tick) begin
                        if (timer_r == TO_LAST) begin
                            timer_r <= '0;
                            await_r <= 1'b0;
                            lose_r  <= 1'b1;
                            state_r <= S_LOSE;
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (start) begin
                        round_r <= 6'd0;
                        win_r   <= 1'b0;
                        lose_r  <= 1'b0;
                        led_r   <= 4'b0000;
                        state_r <= S_ADD;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    idx_r     <= 6'd0;
                    round_r   <= 6'd0;
                    timer_r   <= '0;
                    led_r     <= 4'b0000;
                    showing_r <= 1'b0;
                    await_r   <= 1'b0;
                    win_r     <= 1'b0;
                    lose_r    <= 1'b0;
                end
            endcase
        end
    end

    assign led         = led_r | echo_s;
    assign round       = round_r;
    assign showing     = showing_r;
    assign await_input = await_r;
    assign win         = win_r;
    assign lose        = lose_r;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: a pattern-queue model predicts every output each cycle.
module tb_simon_round_ctrl;

    localparam int MAX_LEN = 3;
    localparam int ON_T    = 2;
    localparam int OFF_T   = 1;
    localparam int TO_T    = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       tick;
    logic [1:0] rnd;
    logic       btn_valid;
    logic [1:0] btn_color;
    logic [3:0] led;
    logic [5:0] round;
    logic       showing;
    logic       await_input;
    logic       win;
    logic       lose;

    logic [3:0] exp_led;
    logic [5:0] exp_round;
    logic       exp_showing, exp_await, exp_win, exp_lose;
    bit         check_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         pat[$];
    int         pos = 0;
    int         in_ticks = 0;

    simon_round_ctrl #(
        .MAX_LEN(MAX_LEN), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .TIMEOUT_TICKS(TO_T)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .tick(tick), .rnd(rnd),
        .btn_valid(btn_valid), .btn_color(btn_color), .led(led), .round(round),
        .showing(showing), .await_input(await_input), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int c);
        return 4'(1 << c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("led", led, exp_led);
            chk("round", round, exp_round);
            chk("showing", showing, exp_showing);
            chk("await_input", await_input, exp_await);
            chk("win", win, exp_win);
            chk("lose", lose, exp_lose);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
    endtask

    task automatic clear_exp();
        exp_led = 4'b0000; exp_round = 6'd0; exp_showing = 1'b0;
        exp_await = 1'b0; exp_win = 1'b0; exp_lose = 1'b0;
    endtask

    // Hold the current expectation for n ticks, optionally spraying ignored inputs
    task automatic wait_ticks(input int n, input bit noise);
        int seen = 0;
        while (seen < n) begin
            if (noise) begin
                btn_valid = (cyc % 3 == 1);
                btn_color = 2'(cyc);
                start     = (cyc % 5 == 2);
            end
            if (tick) seen++;
            step();
        end
        btn_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic playback(input bit noise);
        exp_showing = 1'b1;
        for (int k = 0; k < pat.size(); k++) begin
            exp_led = oh(pat[k]);
            wait_ticks(ON_T, noise);
            exp_led = 4'b0000;
            wait_ticks(OFF_T, noise);
        end
        exp_showing = 1'b0;
        exp_await   = 1'b1;
        pos         = 0;
        in_ticks    = 0;
    endtask

    // Start a new game; returns with the DUT in its first playback step
    task automatic start_game(input logic [1:0] c);
        rnd = c; start = 1'b1;
        step();
        start = 1'b0;
        pat.delete();
        clear_exp();
        step();
        pat.push_back(int'(c));
        exp_round   = 6'(pat.size());
        exp_showing = 1'b1;
        exp_led     = oh(int'(c));
    endtask

    task automatic press(input int c, input logic [1:0] next_rnd, input bit noise);
        rnd = next_rnd; btn_valid = 1'b1; btn_color = 2'(c);
        exp_led = oh(c);
        step();
        btn_valid = 1'b0;
        exp_led   = 4'b0000;
        in_ticks  = 0;
        if (c != pat[pos]) begin
            exp_await = 1'b0; exp_lose = 1'b1;
        end else if (pos == pat.size() - 1) begin
            exp_await = 1'b0;
            if (pat.size() == MAX_LEN) begin
                exp_win = 1'b1; exp_led = 4'b1111;
            end else begin
                step();
                pat.push_back(int'(next_rnd));
                exp_round = 6'(pat.size());
                playback(noise);
            end
        end else begin
            pos++;
        end
    endtask

    task automatic wait_input(input int n);
        int seen = 0;
        while (seen < n && !exp_lose) begin
            if (tick) begin seen++; in_ticks++; end
            step();
            if (in_ticks >= TO_T) begin exp_await = 1'b0; exp_lose = 1'b1; end
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; tick = 1'b0; rnd = 2'd0;
        btn_valid = 1'b0; btn_color = 2'd0;
        clear_exp();
        step(); step();
        chk("rst_led", led, 4'b0000);
        chk("rst_round", round, 6'd0);
        chk("rst_flags", {showing, await_input, win, lose}, 4'b0000);
        clr = 1'b0; check_en = 1'b1;
        step(); step();

        // Game 1: grow to three steps and win
        start_game(2'd2);
        chk("g1_first_led", led, 4'b0100);
        playback(1'b1);
        chk("g1_await", await_input, 1'b1);
        chk("g1_round", round, 6'd1);
        press(2, 2'd0, 1'b1);
        chk("g1_round2", round, 6'd2);
        press(2, 2'd0, 1'b0);
        press(0, 2'd1, 1'b0);
        chk("g1_round3", round, 6'd3);
        press(2, 2'd0, 1'b0);
        press(0, 2'd0, 1'b0);
        press(1, 2'd0, 1'b0);
        chk("win_led", led, 4'b1111);
        chk("win_flag", win, 1'b1);
        chk("win_round", round, 6'd3);
        step(); step();

        // Restart from WIN, then a wrong colour loses
        start_game(2'd2);
        chk("restart_round", round, 6'd1);
        chk("restart_showing", showing, 1'b1);
        playback(1'b0);
        press(1, 2'd0, 1'b0);
        chk("wrong_lose", lose, 1'b1);
        chk("wrong_round", round, 6'd1);
        step();

        // Silence for the full timeout loses
        start_game(2'd3);
        playback(1'b0);
        wait_input(TO_T);
        chk("timeout_lose", lose, 1'b1);
        chk("timeout_await", await_input, 1'b0);
        step();

        // Press on the timeout tick survives and restarts the timer
        start_game(2'd1);
        playback(1'b0);
        press(1, 2'd2, 1'b0);
        wait_input(3);
        while (!tick) step();
        press(1, 2'd0, 1'b0);
        chk("coinc_await", await_input, 1'b1);
        chk("coinc_lose", lose, 1'b0);
        wait_input(3);
        chk("coinc_hold", await_input, 1'b1);
        press(2, 2'd0, 1'b0);
        press(1, 2'd0, 1'b0);
        press(2, 2'd0, 1'b0);
        press(3, 2'd0, 1'b0);
        chk("late_lose_round", round, 6'd3);
        step();

        // Asynchronous clear in the middle of playback
        start_game(2'd0);
        step(); step();
        #2 clr = 1'b1;
        #1;
        chk("clr_led", led, 4'b0000);
        chk("clr_round", round, 6'd0);
        chk("clr_showing", showing, 1'b0);
        pat.delete();
        clear_exp();
        step();
        clr = 1'b0;
        step(); step();
        start_game(2'd3);
        playback(1'b0);
        press(3, 2'd1, 1'b0);
        chk("post_clr_round", round, 6'd2);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
- Game-round sequencer for Sly-Man-Says.
- Each round it appends one random colour to a stored pattern, then plays the pattern back on the four LEDs with tick-based on/off timing.
- It then checks the player's button presses against the pattern and either advances the round or flags win/lose.
- Sits between the LFSR/timebase (tick, rnd) and the LED and score display; the round count feeds the 7-segment score path.

Parameters:
- MAX_LEN, 32, pattern length that wins the game (1..32; round register is 6 bits).
- ON_TICKS, 4, ticks each LED stays lit during playback (>=1).
- OFF_TICKS, 2, ticks of dark gap after each playback step (>=1).
- TIMEOUT_TICKS, 40, ticks allowed between player presses before loss (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-high; forces IDLE and clears all registers.
- start  in  1  one-cycle pulse; begins a new game from IDLE, WIN or LOSE; ignored elsewhere.
- tick  in  1  one-cycle timebase enable; all timers advance only when tick=1.
- rnd  in  2  random colour sampled when a step is appended.
- btn_valid  in  1  one-cycle pulse, debounced player press.
- btn_color  in  2  colour of the press, valid with btn_valid.
- led  out  4  one-hot colour display (bit n = colour n).
- round  out  6  current pattern length / score.
- showing  out  1  high in SHOW_ON and SHOW_OFF.
- await_input  out  1  high in INPUT.
- win  out  1  level, high in WIN.
- lose  out  1  level, high in LOSE.

Behaviour:
- clr=1 (any time, including mid-playback): state=IDLE; round, idx, timer=0; led=0; all flags 0; pattern memory contents don't-care.
- Internal registers: pattern mem[MAX_LEN] x 2 bits; idx (6 bits); timer (wide enough for max(ON,OFF,TIMEOUT)).
- IDLE: led=0. start -> ADD with round=0.
- ADD (1 cycle):
  - mem[round] <= rnd; round <= round+1; idx <= 0; timer <= 0.
  - -> SHOW_ON.
- SHOW_ON: led = onehot(mem[idx]).
  - On tick: timer++.
  - On tick with timer==ON_TICKS-1: timer<=0 -> SHOW_OFF.
- SHOW_OFF: led=0.
  - On tick with timer==OFF_TICKS-1: timer<=0.
  - If idx==round-1: idx<=0 -> INPUT. Else idx++ -> SHOW_ON.
- INPUT: led = onehot(btn_color) in the cycle btn_valid=1, else 0.
  - btn_valid with btn_color==mem[idx], idx<round-1: idx++, timer<=0, stay.
  - Correct press with idx==round-1: if round==MAX_LEN -> WIN, else -> ADD.
  - Wrong colour: -> LOSE.
  - No press: tick increments timer; on tick with timer==TIMEOUT_TICKS-1 -> LOSE.
  - btn_valid and tick in the same cycle: press takes priority; timer resets to 0.
- WIN: win=1, led=4'b1111, round holds. LOSE: lose=1, led=0, round holds (final score).
  - From WIN or LOSE, start -> round<=0 -> ADD.
- btn_valid outside INPUT: ignored, no state change. start outside IDLE/WIN/LOSE: ignored.
- Transitions take effect on the clock edge after the qualifying input. A press is checked in the same cycle it arrives.
- round never exceeds MAX_LEN. No wrap-around.

Test Plan:
Bench settings: MAX_LEN=3, ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=4, tick every 4th cycle.
- clr high mid-SHOW_ON -> led=0, round=0, all flags 0 immediately (asynchronous, no clock edge needed).
- start with rnd=2 -> ADD then SHOW_ON. Expect led=4'b0100 for 2 ticks, then 0 for 1 tick, then await_input=1, round=1.
- Round 1, press colour 2 -> round 2 appended (rnd=0). Playback shows 0100, 0000, 0001, 0000. Pressing 2,0 reaches round 3.
- Play correct presses through round 3 -> win=1, led=4'b1111, round=3. A following start -> round=1, showing=1.
- In INPUT, press colour 1 when mem[0]=2 -> lose=1, round unchanged.
- In INPUT, send no press for 4 ticks -> lose=1.
- Press coincident with tick on the 4th tick -> no loss; timer restarts.
- btn_valid pulses during playback -> ignored; playback sequence and idx unchanged.
